// File: rtl/base_pack.sv
// base_pack: packs RATIO narrow valid/ready beats into one wide word and
// presents it on a registered valid/ready output that feeds a base_fifo.
// A beat carrying the end marker, or an idle timeout, closes a partial word.
//
// Ports:
//   clk   - clock, rising-edge state updates
//   reset - asynchronous reset, active low
//   i_v   - narrow beat valid
//   i_r   - narrow beat ready (combinational from o_r by design)
//   i_d   - narrow beat data
//   i_e   - end marker, qualified by i_v
//   o_v   - wide word valid (FIFO i_v)
//   o_r   - wide word accepted (FIFO i_r)
//   o_d   - packed word, lane k at o_d[(k+1)*width-1 : k*width]
//   o_c   - number of valid lanes minus one
//   o_e   - word was closed by the end marker
module base_pack #(
  parameter int width     = 8,
  parameter int LOG_RATIO = 2,
  parameter int RATIO     = 2 ** LOG_RATIO,
  parameter int TIMEOUT   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_v,
  output logic                   i_r,
  input  logic [width-1:0]       i_d,
  input  logic                   i_e,
  output logic                   o_v,
  input  logic                   o_r,
  output logic [width*RATIO-1:0] o_d,
  output logic [LOG_RATIO-1:0]   o_c,
  output logic                   o_e
);

  localparam logic [15:0]          TO_MAX = 16'(TIMEOUT);
  localparam bit                   TO_EN  = (TIMEOUT > 0);
  localparam logic [LOG_RATIO-1:0] LAST   = LOG_RATIO'(RATIO - 1);

  logic [LOG_RATIO-1:0]   cnt_q, cnt_d;
  logic [width*RATIO-1:0] asm_q, asm_d;
  logic [15:0]            idle_q, idle_d;
  logic                   o_v_q, o_v_d;
  logic [width*RATIO-1:0] o_d_q, o_d_d;
  logic [LOG_RATIO-1:0]   o_c_q, o_c_d;
  logic                   o_e_q, o_e_d;

  logic                   acc_s;
  logic                   close_s;
  logic                   tmo_s;
  logic [width*RATIO-1:0] merged_s;

  // A new beat may enter whenever the output slot is empty or draining now.
  assign i_r     = ~o_v_q | o_r;
  assign acc_s   = i_v & i_r;
  assign close_s = acc_s & (i_e | (cnt_q == LAST));
  // Flush only in cycles without an accept; an accept restarts the idle count.
  assign tmo_s   = TO_EN & ~acc_s & (idle_q == TO_MAX) & (cnt_q != '0) & i_r;

  assign o_v = o_v_q;
  assign o_d = o_d_q;
  assign o_c = o_c_q;
  assign o_e = o_e_q;

  // Assembly lanes with the current beat overlaid at lane cnt; lanes above
  // cnt are already zero because the buffer clears on every close.
  always_comb begin
    merged_s = asm_q;
    for (int k = 0; k < RATIO; k++) begin
      if (acc_s && (cnt_q == LOG_RATIO'(k))) begin
        merged_s[k*width +: width] = i_d;
      end else begin
        merged_s[k*width +: width] = asm_q[k*width +: width];
      end
    end
  end

  // Next-state for lane counter, assembly buffer, idle counter and output slot.
  always_comb begin
    cnt_d  = cnt_q;
    asm_d  = asm_q;
    o_d_d  = o_d_q;
    o_c_d  = o_c_q;
    o_e_d  = o_e_q;
    if (o_v_q && o_r) begin
      o_v_d = 1'b0;
    end else begin
      o_v_d = o_v_q;
    end

    if (close_s) begin
      o_v_d = 1'b1;
      o_d_d = merged_s;
      o_c_d = cnt_q;
      o_e_d = i_e;
      cnt_d = '0;
      asm_d = '0;
    end else if (acc_s) begin
      asm_d = merged_s;
      cnt_d = cnt_q + LOG_RATIO'(1);
    end else if (tmo_s) begin
      o_v_d = 1'b1;
      o_d_d = asm_q;
      o_c_d = cnt_q - LOG_RATIO'(1);
      o_e_d = 1'b0;
      cnt_d = '0;
      asm_d = '0;
    end else begin
      cnt_d = cnt_q;
    end

    if (!TO_EN || acc_s || tmo_s || (cnt_q == '0)) begin
      idle_d = 16'd0;
    end else if (idle_q < TO_MAX) begin
      idle_d = idle_q + 16'd1;
    end else begin
      idle_d = idle_q;
    end
  end

  // State registers; reset discards any partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      asm_q  <= '0;
      idle_q <= 16'd0;
      o_v_q  <= 1'b0;
      o_d_q  <= '0;
      o_c_q  <= '0;
      o_e_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      asm_q  <= asm_d;
      idle_q <= idle_d;
      o_v_q  <= o_v_d;
      o_d_q  <= o_d_d;
      o_c_q  <= o_c_d;
      o_e_q  <= o_e_d;
    end
  end

endmodule

// File: doc/base_pack.md
Name: base_pack

Overview:
- Upstream packer that feeds a base_fifo instance.
- Collects RATIO narrow beats from a valid/ready source and assembles them into one wide word, which it pushes into the FIFO input.
- An end marker or an idle timeout flushes a partial word early.
- Lets narrow producers share wide FIFOs without wasting entries.

Parameters:
- width, 8, bits per narrow input beat.
- LOG_RATIO, 2, log2 of beats per wide word; must be at least 1.
- RATIO, 2**LOG_RATIO, beats per wide word; derived, do not override.
- TIMEOUT, 0, idle cycles before a partial word is flushed; 0 disables the timeout; maximum value 65535.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous reset, active-low (0 = reset asserted).
- i_v  input  1  input beat valid.
- i_r  output  1  input beat ready.
- i_d  input  width  input beat data.
- i_e  input  1  end marker; qualified by i_v.
- o_v  output  1  wide word valid; drives the FIFO i_v.
- o_r  input  1  wide word accepted; driven by the FIFO i_r.
- o_d  output  width*RATIO  packed word; lane k is o_d[(k+1)*width-1 : k*width].
- o_c  output  LOG_RATIO  number of valid lanes minus 1.
- o_e  output  1  word closed by i_e.

Behaviour:
- Storage:
  - Assembly buffer asm_d holds RATIO lanes.
  - Lane counter cnt holds 0..RATIO-1 and is the index of the next free lane.
  - Idle counter is 16 bits.
  - Output register holds o_v, o_d, o_c and o_e.
- Reset (asynchronous, reset=0):
  - cnt=0, asm_d=0, idle counter=0.
  - o_v=0, o_d=0, o_c=0, o_e=0.
  - Any partial word is discarded.
  - Deassertion takes effect at the next clk edge.
- Ready rule: i_r = ~o_v | o_r.
  - This is a combinational path from o_r to i_r, by design.
  - It gives full throughput: a new beat may close a word in the same cycle the previous word drains.
- Beat accept (i_v & i_r): i_d is written into lane cnt.
  - Close condition: i_e=1 or cnt==RATIO-1. On close:
    - The output register loads the assembled lanes including the current beat.
    - Lanes above cnt are zero.
    - o_c=cnt, o_e=i_e, o_v=1.
    - asm_d clears to 0 and cnt returns to 0.
  - Otherwise cnt increments by 1.
- Output drain: if o_v & o_r and no word closes this cycle, o_v goes to 0 next cycle.
  - o_d, o_c and o_e hold their values when o_v=0.
  - o_d, o_c and o_e are stable while o_v & ~o_r.
- Latency: one cycle from the closing beat's accept edge to o_v=1.
- Timeout, only when TIMEOUT>0:
  - The idle counter clears on every accepted beat and whenever cnt==0.
  - Otherwise it increments each cycle, saturating at TIMEOUT.
  - When it equals TIMEOUT, cnt>0 and (~o_v | o_r), the partial word closes:
    - o_c=cnt-1, o_e=0, o_v=1.
    - cnt=0, idle counter=0.
  - Timeout flush and beat accept never coincide: the counter is cleared by any accept, so the flush fires only in cycles with no accept.
- A beat with i_e=1 when cnt==0 produces a single-lane word (o_c=0, o_e=1).
- While o_v=1 and o_r=0, i_r=0: no beats are accepted and cnt holds.
- Nothing is dropped or duplicated. The number of accepted beats equals the sum over delivered words of (o_c+1).

Test Plan:
- Defaults, i_v held 1, o_r=1, i_d=0x11,0x22,0x33,0x44 with i_e=0 -> one cycle later o_v=1, o_d=0x44332211, o_c=3, o_e=0; i_r stays 1 throughout.
- i_d=0xAA, then 0xBB with i_e=1 -> o_d=0x0000BBAA, o_c=1, o_e=1; the next beat lands in lane 0.
- Fill a word with o_r=0 -> o_v holds and i_r=0 until o_r=1; then 8 beats at full rate with o_r=1 give two words on consecutive word boundaries and no bubble cycle.
- TIMEOUT=5: accept 0x5A, then i_v=0 -> o_v rises 6 cycles after the accept edge with o_d=0x0000005A, o_c=0, o_e=0; repeat with o_r=0 -> the flush waits and no data is lost.
- Accept 3 beats, assert reset=0 mid-cycle -> o_v, cnt and o_d are 0 immediately without a clock edge; after release a fresh 4-beat sequence yields only the new data.
- Random i_v/o_r/i_e over 10k beats against a scoreboard -> ordered, lossless delivery; o_c and o_e match the model; o_d is stable while o_v & ~o_r.
